keypad_scanner: RTL and testbench

//  Parametrised matrix-keypad scanner; next-generation replacement for the fixed 4x4 scan/decode block.

---
 rtl/keypad_pkg.sv | 10 +
 rtl/keypad_fifo.sv | 52 +++++
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: scan FSM state type and key-code width helper shared by the keypad scanner files.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} scan_state_t;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: registered-output synchronous FIFO for key events; a push is not visible until the next clk.
module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign dout  = mem_q[rd_q];

    // a pop frees the slot a simultaneous push into a full FIFO needs
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWSxCOLS matrix keypad scan, debounce, encode and event queue.
// Define KEYPAD_REPEAT_EN to add auto-repeat of a held key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int          ROWS         = 4,
    parameter int          COLS         = 4,
    parameter logic [31:0] TICK_INC     = 32'd53687,
    parameter int          DEBOUNCE     = 3,
    parameter int          FIFO_DEPTH   = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int          REPEAT_DELAY = 64,
    parameter int          REPEAT_RATE  = 16
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ROWS-1:0]                   row,
    output logic [COLS-1:0]                   col,
    output logic [code_width(ROWS, COLS)-1:0] key_code,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic                              overflow
);
    localparam int CW  = code_width(ROWS, COLS);
    localparam int CIW = $clog2(COLS);
    localparam int RIW = $clog2(ROWS);
    localparam int NW  = $clog2(DEBOUNCE + 1);

    scan_state_t           state_q, state_d;
    logic [31:0]           acc_q, acc_d;
    logic [1:0][ROWS-1:0]  sync_q, sync_d;
    logic [ROWS-1:0]       row_s, pat_q, pat_d;
    logic [CIW-1:0]        col_q, col_d, col_nxt;
    logic [NW-1:0]         cnt_q, cnt_d;
    logic [RIW-1:0]        row_idx;
    logic [CW-1:0]         code;
    logic                  tick, press_ok, push, rep_push, push_all, full, empty;
    logic                  overflow_q, overflow_d;

    assign {tick, acc_d} = {1'b0, acc_q} + {1'b0, TICK_INC};
    assign sync_d     = {sync_q[0], row};
    assign row_s      = sync_q[1];
    assign press_ok   = $onehot(row_s);
    assign col_nxt    = (col_q == CIW'(COLS - 1)) ? '0 : col_q + CIW'(1);
    assign col        = COLS'(1) << col_q;
    assign push_all   = push | rep_push;
    assign key_valid  = !empty;
    assign overflow   = overflow_q;
    assign overflow_d = overflow_q | (push_all && full && !(key_valid && key_ready));

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++) if (pat_q[i]) row_idx = RIW'(i);
        code = CW'(int'(row_idx) * COLS + int'(col_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        col_d   = col_q;
        push    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (press_ok) begin
                        state_d = DEB_PRESS;
                        cnt_d   = NW'(1);
                        pat_d   = row_s;
                    end else begin
                        col_d = col_nxt;
                    end
                end
                DEB_PRESS: begin
                    if (row_s == pat_q) begin
                        cnt_d = cnt_q + NW'(1);
                        if (cnt_d == NW'(DEBOUNCE)) begin
                            push    = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (row_s == '0) begin
                        state_d = DEB_REL;
                        cnt_d   = NW'(1);
                    end
                end
                default: begin
                    if (row_s != '0) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                        if (cnt_d == NW'(DEBOUNCE)) begin
                            state_d = SCAN;
                            col_d   = col_nxt;
                        end
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    logic [RW-1:0] rep_q, rep_d, rep_nxt;

    // counts ticks held; after the first repeat it cycles back to REPEAT_DELAY every REPEAT_RATE ticks
    always_comb begin
        rep_nxt  = rep_q + RW'(1);
        rep_d    = (state_q == SCAN || state_q == DEB_PRESS) ? '0 : rep_q;
        rep_push = 1'b0;
        if (tick && state_q == HELD && row_s != '0) begin
            rep_push = rep_nxt == RW'(REPEAT_DELAY) || rep_nxt == RW'(REPEAT_DELAY + REPEAT_RATE);
            rep_d    = (rep_nxt == RW'(REPEAT_DELAY + REPEAT_RATE)) ? RW'(REPEAT_DELAY) : rep_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_push = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            sync_q     <= '0;
            state_q    <= SCAN;
            cnt_q      <= '0;
            pat_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
        end
    end

    keypad_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_all),
        .pop   (key_ready),
        .din   (code),
        .dout  (key_code),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, anti-ghosting, FIFO overflow and reset.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_ready = 1'b1;
    logic [3:0] row = '0;
    logic [3:0] col, key_code;
    logic       key_valid, overflow;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] drain_codes [4] = '{4'd1, 4'd7, 4'd9, 4'd15};

    keypad_scanner #(
        .ROWS(4), .COLS(4), .TICK_INC(32'h8000_0000), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // the scan tick fires on every second clk edge after reset release
    task automatic tick();
        clk1();
        clk1();
    endtask

    // drive a press from SCAN with row 0 settled; it is captured one column on, held 4 ticks, then released
    task automatic press(input logic [3:0] r, input logic [3:0] code, input logic [3:0] c, input bit chk);
        row = r;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("deb_col", col, c);
            if (chk) check("deb_no_valid", key_valid, 0);
        end
        tick();
        check("push_col", col, c);
        if (chk) begin
            check("push_valid", key_valid, 1);
            check("push_code", key_code, code);
        end
        row = '0;
        clk1();
        if (chk) check("valid_one_clk", key_valid, 0);
        clk1();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rel_col", col, c);
        end
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", col, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_code", key_code, 0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("walk_col", col, 32'd1 << ((i + 1) % 4));
        end

        press(4'b0100, 4'd9, 4'b0010, 1'b1);
        check("after_press_col", col, 4'b0100);

        for (int i = 0; i < 10; i++) begin
            row = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            check("bounce_col", col, 4'b1000);
            check("bounce_valid", key_valid, 0);
        end
        tick();
        check("bounce_settle_col", col, 4'b1000);
        tick();
        check("scan_resume_col", col, 4'b0001);
        press(4'b0001, 4'd1, 4'b0010, 1'b1);
        check("after_stable_col", col, 4'b0100);

        row = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ghost_col", col, 32'd1 << ((i + 3) % 4));
            check("ghost_valid", key_valid, 0);
        end
        row = '0;
        tick();
        check("ghost_tail_col", col, 4'b1000);
        tick();
        check("ghost_end_col", col, 4'b0001);

        key_ready = 1'b0;
        press(4'b0001, 4'd1, 4'b0010, 1'b0);
        check("q1_overflow", overflow, 0);
        press(4'b0010, 4'd7, 4'b1000, 1'b0);
        press(4'b0100, 4'd9, 4'b0010, 1'b0);
        press(4'b1000, 4'd15, 4'b1000, 1'b0);
        check("full_overflow", overflow, 0);
        check("full_valid", key_valid, 1);
        check("hold_code", key_code, 4'd1);
        press(4'b0010, 4'd5, 4'b0010, 1'b0);
        check("drop_overflow", overflow, 1);
        check("drop_col", col, 4'b0100);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", key_valid, 1);
            check("drain_code", key_code, drain_codes[i]);
            clk1();
        end
        check("drained_valid", key_valid, 0);
        check("sticky_overflow", overflow, 1);

        row = 4'b0100;
        tick();
        check("pre_rst_col", col, 4'b0010);
        tick();
        check("deb_rst_col", col, 4'b0010);
        reset_n = 1'b0;
        row = '0;
        #1;
        check("mid_rst_col", col, 4'b0001);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("restart_col1", col, 4'b0010);
        check("restart_valid1", key_valid, 0);
        tick();
        check("restart_col2", col, 4'b0100);
        check("restart_valid2", key_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
